// File: rtl/mult_eval_sequencer.sv
// Stimulus sequencer that drives LFSR-generated operand pairs into an external multiplier
// and accumulates error statistics of its product against the exact result.
module mult_eval_sequencer #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned NUM_VECTORS   = 20,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [15:0]          seed,
  output logic [WIDTH-1:0]     op_a,
  output logic [WIDTH-1:0]     op_b,
  input  logic [2*WIDTH-1:0]   dut_p,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          vec_count,
  output logic [15:0]          err_count,
  output logic [31:0]          err_dist_sum,
  output logic [2*WIDTH-1:0]   max_err
);

  localparam int unsigned PW         = 2 * WIDTH;
  localparam logic [7:0]  SettleLast = 8'(SETTLE_CYCLES - 1);
  localparam logic [15:0] NumVec     = 16'(NUM_VECTORS);
  localparam logic [15:0] SeedAlt    = 16'hACE1;
  localparam logic [15:0] LfsrTaps   = 16'hB400;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StApply,
    StCheck,
    StNext,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [7:0]      settle_q, settle_d;
  logic [15:0]     vec_q, vec_d;
  logic [15:0]     err_q, err_d;
  logic [31:0]     sum_q, sum_d;
  logic [PW-1:0]   max_q, max_d;

  logic [PW-1:0]   golden;
  logic [PW-1:0]   diff;
  logic [32:0]     sum_ext;
  logic [15:0]     vec_inc;

  assign op_a = lfsr_q[WIDTH-1:0];
  assign op_b = lfsr_q[PW-1:WIDTH];

  // Operands are zero-extended first so the product keeps its full width.
  assign golden  = PW'(op_a) * PW'(op_b);
  assign diff    = (dut_p >= golden) ? (dut_p - golden) : (golden - dut_p);
  assign sum_ext = {1'b0, sum_q} + {{(33 - PW){1'b0}}, diff};
  assign vec_inc = vec_q + 16'd1;

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    settle_d = settle_q;
    vec_d    = vec_q;
    err_d    = err_q;
    sum_d    = sum_q;
    max_d    = max_q;
    case (state_q)
      StIdle: begin
        if (start) state_d = StLoad;
      end
      StLoad: begin
        lfsr_d   = (seed == 16'h0000) ? SeedAlt : seed;
        settle_d = 8'd0;
        vec_d    = 16'd0;
        err_d    = 16'd0;
        sum_d    = 32'd0;
        max_d    = '0;
        state_d  = StApply;
      end
      StApply: begin
        if (settle_q == SettleLast) begin
          state_d = StCheck;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      StCheck: begin
        vec_d = vec_inc;
        if (diff != '0) err_d = err_q + 16'd1;
        sum_d = sum_ext[32] ? 32'hFFFF_FFFF : sum_ext[31:0];
        if (diff > max_q) max_d = diff;
        state_d = (vec_inc == NumVec) ? StDone : StNext;
      end
      StNext: begin
        lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrTaps : 16'h0000);
        settle_d = 8'd0;
        state_d  = StApply;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      lfsr_q   <= 16'h0000;
      settle_q <= 8'd0;
      vec_q    <= 16'd0;
      err_q    <= 16'd0;
      sum_q    <= 32'd0;
      max_q    <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      settle_q <= settle_d;
      vec_q    <= vec_d;
      err_q    <= err_d;
      sum_q    <= sum_d;
      max_q    <= max_d;
    end
  end

  assign busy         = (state_q != StIdle);
  assign done         = (state_q == StDone);
  assign vec_count    = vec_q;
  assign err_count    = err_q;
  assign err_dist_sum = sum_q;
  assign max_err      = max_q;

endmodule

// File: tb/tb_mult_eval_sequencer.sv
// Randomized bench: three sequencer instances with different parameters, each looped back
// through a behavioural multiplier that can be exact, stuck at a constant, or faulty.
module tb_mult_eval_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A: WIDTH=2, 20 vectors, settle 1
  logic a_start; logic [15:0] a_seed; logic [1:0] a_op_a, a_op_b; logic [3:0] a_p;
  logic a_busy, a_done; logic [15:0] a_vc, a_ec; logic [31:0] a_sum; logic [3:0] a_max;
  int a_mode = 0, a_cval = 0;
  // Instance B: WIDTH=2, 1 vector, settle 1
  logic b_start; logic [15:0] b_seed; logic [1:0] b_op_a, b_op_b; logic [3:0] b_p;
  logic b_busy, b_done; logic [15:0] b_vc, b_ec; logic [31:0] b_sum; logic [3:0] b_max;
  int b_mode = 0, b_cval = 0;
  // Instance C: WIDTH=8, 9 vectors, settle 3
  logic c_start; logic [15:0] c_seed; logic [7:0] c_op_a, c_op_b; logic [15:0] c_p;
  logic c_busy, c_done; logic [15:0] c_vc, c_ec; logic [31:0] c_sum; logic [15:0] c_max;
  int c_mode = 0, c_cval = 0;

  // Multiplier under test: 0 exact, 1 stuck at cval, 2 corrupts some operand pairs.
  function automatic int fmul(input int mode, input int cval, input int a, input int b,
                              input int w);
    int g, m;
    g = a * b;
    m = (1 << (2 * w)) - 1;
    fmul = g;
    if (mode == 1) fmul = cval & m;
    else if (mode == 2 && ((a + b) % 3 == 0)) fmul = (g ^ ((a << 1) | 1)) & m;
  endfunction

  assign a_p = 4'(fmul(a_mode, a_cval, int'(a_op_a), int'(a_op_b), 2));
  assign b_p = 4'(fmul(b_mode, b_cval, int'(b_op_a), int'(b_op_b), 2));
  assign c_p = 16'(fmul(c_mode, c_cval, int'(c_op_a), int'(c_op_b), 8));

  mult_eval_sequencer #(.WIDTH(2), .NUM_VECTORS(20), .SETTLE_CYCLES(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .seed(a_seed), .op_a(a_op_a), .op_b(a_op_b),
    .dut_p(a_p), .busy(a_busy), .done(a_done), .vec_count(a_vc), .err_count(a_ec),
    .err_dist_sum(a_sum), .max_err(a_max));
  mult_eval_sequencer #(.WIDTH(2), .NUM_VECTORS(1), .SETTLE_CYCLES(1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .seed(b_seed), .op_a(b_op_a), .op_b(b_op_b),
    .dut_p(b_p), .busy(b_busy), .done(b_done), .vec_count(b_vc), .err_count(b_ec),
    .err_dist_sum(b_sum), .max_err(b_max));
  mult_eval_sequencer #(.WIDTH(8), .NUM_VECTORS(9), .SETTLE_CYCLES(3)) u_c (
    .clk(clk), .rst_n(rst_n), .start(c_start), .seed(c_seed), .op_a(c_op_a), .op_b(c_op_b),
    .dut_p(c_p), .busy(c_busy), .done(c_done), .vec_count(c_vc), .err_count(c_ec),
    .err_dist_sum(c_sum), .max_err(c_max));

  // Walk the LFSR sequence with plain arithmetic and tally the statistics of a run.
  task automatic ref_model(input int w, input int n, input int sd, input int mode,
                           input int cval, output int vc, output int ec, output longint sum,
                           output int mx, output int la, output int lb);
    int lf, m, a, b, g, p, d;
    lf = (sd == 0) ? 'hACE1 : sd;
    m  = (1 << w) - 1;
    vc = 0; ec = 0; sum = 0; mx = 0; la = 0; lb = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) lf = (lf >> 1) ^ (((lf & 1) != 0) ? 'hB400 : 0);
      a = lf & m;
      b = (lf >> w) & m;
      g = a * b;
      p = fmul(mode, cval, a, b, w);
      d = (p > g) ? p - g : g - p;
      if (d != 0) ec++;
      sum += d;
      if (sum > 64'hFFFF_FFFF) sum = 64'hFFFF_FFFF;
      if (d > mx) mx = d;
      vc++;
      la = a; lb = b;
    end
  endtask

  function automatic logic done_of(input int which);
    done_of = (which == 0) ? a_done : (which == 1) ? b_done : c_done;
  endfunction

  task automatic drive_start(input int which, input logic v);
    case (which)
      0: a_start = v;
      1: b_start = v;
      default: c_start = v;
    endcase
  endtask

  // Start a run and report edges from the start edge to the first done, plus done pulse count.
  task automatic run_dut(input int which, input logic [15:0] s, input bit spam,
                         output int edges, output int pulses);
    bit got;
    @(negedge clk);
    case (which)
      0: a_seed = s;
      1: b_seed = s;
      default: c_seed = s;
    endcase
    drive_start(which, 1'b1);
    @(posedge clk); #1;
    drive_start(which, 1'b0);
    edges = 0; pulses = 0; got = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(posedge clk); #1;
      edges++;
      if (spam && i < 40) drive_start(which, logic'(i % 2));
      if (done_of(which)) begin pulses++; got = 1; end
    end
    drive_start(which, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done_of(which)) pulses++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", a_busy); end
    total++; if (a_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", a_done); end
    total++; if ({a_op_a, a_op_b} !== 4'h0) begin bad++; $display("FAIL reset_ops got=%h want=0", {a_op_a, a_op_b}); end
    total++; if ({a_vc, a_ec} !== 32'h0) begin bad++; $display("FAIL reset_counts got=%h want=0", {a_vc, a_ec}); end
    total++; if ({a_sum, a_max} !== 36'h0) begin bad++; $display("FAIL reset_err got=%h want=0", {a_sum, a_max}); end
    total++; if ({c_op_a, c_op_b, c_busy} !== 17'h0) begin bad++; $display("FAIL reset_c got=%h want=0", {c_op_a, c_op_b, c_busy}); end
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    total++; if ({a_busy, b_busy, c_busy} !== 3'b000) begin bad++; $display("FAIL idle_after_reset got=%b want=000", {a_busy, b_busy, c_busy}); end
  endtask

  task automatic test_loopback;
    int edges, pulses;
    a_mode = 0;
    run_dut(0, 16'h000B, 1'b0, edges, pulses);
    total++; if (edges != 60) begin bad++; $display("FAIL loop_latency got=%0d want=60", edges); end
    total++; if (pulses != 1) begin bad++; $display("FAIL loop_pulses got=%0d want=1", pulses); end
    total++; if (a_vc !== 16'd20) begin bad++; $display("FAIL loop_vec got=%0d want=20", a_vc); end
    total++; if ({a_ec, a_sum, a_max} !== 52'h0) begin bad++; $display("FAIL loop_err got=%h want=0", {a_ec, a_sum, a_max}); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL loop_idle got=%b want=0", a_busy); end
  endtask

  task automatic test_const_product;
    int edges, pulses;
    int cv[2] = '{0, 15};
    int want[2] = '{6, 9};
    b_mode = 1;
    for (int k = 0; k < 2; k++) begin
      b_cval = cv[k];
      run_dut(1, 16'h000B, 1'b0, edges, pulses);
      total++; if (edges != 3) begin bad++; $display("FAIL const_latency got=%0d want=3", edges); end
      total++; if ({b_op_a, b_op_b} !== 4'b1110) begin bad++; $display("FAIL const_ops got=%0d,%0d want=3,2", b_op_a, b_op_b); end
      total++; if (b_ec !== 16'd1) begin bad++; $display("FAIL const_errs got=%0d want=1", b_ec); end
      total++; if (b_sum !== 32'(want[k])) begin bad++; $display("FAIL const_sum got=%0d want=%0d", b_sum, want[k]); end
      total++; if (b_max !== 4'(want[k])) begin bad++; $display("FAIL const_max got=%0d want=%0d", b_max, want[k]); end
    end
  endtask

  task automatic test_seed_zero;
    int edges, pulses;
    b_mode = 0;
    run_dut(1, 16'h0000, 1'b0, edges, pulses);
    total++; if ({b_op_a, b_op_b} !== 4'b0100) begin bad++; $display("FAIL seed0_ops got=%0d,%0d want=1,0", b_op_a, b_op_b); end
    total++; if ({b_vc, b_ec} !== {16'd1, 16'd0}) begin bad++; $display("FAIL seed0_counts got=%0d,%0d want=1,0", b_vc, b_ec); end
  endtask

  task automatic test_random;
    int edges, pulses, vc, ec, mx, la, lb, sd;
    longint sum;
    for (int r = 0; r < 6; r++) begin
      sd = (r == 0) ? 0 : int'($urandom_range(0, 65535));
      c_mode = (r == 5) ? 1 : 2;
      c_cval = int'($urandom_range(0, 65535));
      ref_model(8, 9, sd, c_mode, c_cval, vc, ec, sum, mx, la, lb);
      run_dut(2, 16'(sd), 1'b0, edges, pulses);
      total++; if (edges != 45) begin bad++; $display("FAIL rand_latency seed=%h got=%0d want=45", sd, edges); end
      total++; if (c_vc !== 16'(vc) || c_ec !== 16'(ec)) begin bad++; $display("FAIL rand_counts seed=%h got=%0d,%0d want=%0d,%0d", sd, c_vc, c_ec, vc, ec); end
      total++; if (c_sum !== 32'(sum)) begin bad++; $display("FAIL rand_sum seed=%h got=%0d want=%0d", sd, c_sum, sum); end
      total++; if (c_max !== 16'(mx)) begin bad++; $display("FAIL rand_max seed=%h got=%0d want=%0d", sd, c_max, mx); end
      total++; if (c_op_a !== 8'(la) || c_op_b !== 8'(lb)) begin bad++; $display("FAIL rand_ops seed=%h got=%0d,%0d want=%0d,%0d", sd, c_op_a, c_op_b, la, lb); end
    end
  endtask

  task automatic test_start_spam;
    int edges, pulses, vc, ec, mx, la, lb;
    longint sum;
    a_mode = 2;
    ref_model(2, 20, 'h5A3C, 2, 0, vc, ec, sum, mx, la, lb);
    run_dut(0, 16'h5A3C, 1'b1, edges, pulses);
    total++; if (edges != 60) begin bad++; $display("FAIL spam_latency got=%0d want=60", edges); end
    total++; if (pulses != 1) begin bad++; $display("FAIL spam_pulses got=%0d want=1", pulses); end
    total++; if (a_vc !== 16'(vc) || a_ec !== 16'(ec)) begin bad++; $display("FAIL spam_counts got=%0d,%0d want=%0d,%0d", a_vc, a_ec, vc, ec); end
    total++; if (a_sum !== 32'(sum) || a_max !== 4'(mx)) begin bad++; $display("FAIL spam_err got=%0d,%0d want=%0d,%0d", a_sum, a_max, sum, mx); end
  endtask

  task automatic test_reset_mid;
    int edges, pulses, vc, ec, mx, la, lb;
    longint sum;
    a_mode = 2;
    @(negedge clk); a_seed = 16'h1234; a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    total++; if ({a_busy, a_done} !== 2'b00) begin bad++; $display("FAIL midrst_flags got=%b want=00", {a_busy, a_done}); end
    total++; if ({a_op_a, a_op_b, a_vc, a_ec, a_sum, a_max} !== 72'h0) begin bad++; $display("FAIL midrst_outputs got=%h want=0", {a_op_a, a_op_b, a_vc, a_ec, a_sum, a_max}); end
    @(negedge clk); rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (a_done || a_busy) pulses++;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL midrst_quiet got=%0d want=0", pulses); end
    ref_model(2, 20, 'h1234, 2, 0, vc, ec, sum, mx, la, lb);
    run_dut(0, 16'h1234, 1'b0, edges, pulses);
    total++; if (edges != 60 || pulses != 1) begin bad++; $display("FAIL midrst_rerun got=%0d,%0d want=60,1", edges, pulses); end
    total++; if (a_vc !== 16'(vc) || a_ec !== 16'(ec) || a_sum !== 32'(sum)) begin bad++; $display("FAIL midrst_stats got=%0d,%0d,%0d want=%0d,%0d,%0d", a_vc, a_ec, a_sum, vc, ec, sum); end
  endtask

  initial begin
    a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
    a_seed = 16'h0; b_seed = 16'h0; c_seed = 16'h0;
    test_reset();
    test_loopback();
    test_const_product();
    test_seed_zero();
    test_random();
    test_start_spam();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
